// File: rtl/alu_src_sel_pkg.sv
// Shared constants for the ALU B-operand source selector: source indices,
// default parameter values and the accept-classification type.
package alu_src_sel_pkg;

    localparam int SRC_B    = 0;
    localparam int SRC_FOUR = 1;
    localparam int SRC_SHL2 = 2;
    localparam int SRC_SEXT = 3;
    localparam int SRC_MEM  = 4;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_N_SRC     = SRC_MEM + 1;
    localparam int DEFAULT_SEL_W     = 3;
    localparam int DEFAULT_ERR_CNT_W = 8;

    // What happened on the input port this cycle.
    typedef enum logic [1:0] {
        BEAT_NONE,
        BEAT_LEGAL,
        BEAT_ILLEGAL
    } beat_kind_e;

endpackage

// File: rtl/alu_src_skid.sv
// One-entry skid register holding a {sel, data} beat while the output
// register of alu_src_sel is stalled.
module alu_src_skid #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] din,
    output logic         full,
    output logic [W-1:0] dout
);

    // load only happens while the output is stalled and drain only while it
    // is free, so the two never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_src_sel.sv
// Registered ALU B-operand selector with valid/ready output and illegal-select
// counter. Define ALU_SRC_SEL_SKID_EN to add a one-entry skid buffer.
module alu_src_sel
    import alu_src_sel_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int N_SRC     = DEFAULT_N_SRC,
    parameter int SEL_W     = DEFAULT_SEL_W,
    parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   sel_err,
    output logic [ERR_CNT_W-1:0]   err_cnt
);

    localparam int BEAT_W = WIDTH + SEL_W;

    logic             sel_legal;
    logic [WIDTH-1:0] sel_data;
    beat_kind_e       beat_kind;
    logic             acc_legal;
    logic             load_out;
    logic             clear_out;
    logic [BEAT_W-1:0] next_beat;

    assign sel_legal = ({1'b0, sel} < (SEL_W + 1)'(N_SRC));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == i[SEL_W-1:0]) begin
                sel_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        beat_kind = BEAT_NONE;
        if (in_valid && in_ready) begin
            beat_kind = sel_legal ? BEAT_LEGAL : BEAT_ILLEGAL;
        end
    end

    assign acc_legal = (beat_kind == BEAT_LEGAL);

`ifdef ALU_SRC_SEL_SKID_EN
    logic              out_free;
    logic              skid_full;
    logic              skid_load;
    logic              skid_drain;
    logic [BEAT_W-1:0] skid_beat;

    assign out_free   = !out_valid || out_ready;
    assign skid_load  = acc_legal && !out_free;
    assign skid_drain = out_free && skid_full;

    // Ready is the registered skid-empty flag; only reset gates it.
    assign in_ready = !reset && !skid_full;

    alu_src_skid #(
        .W(BEAT_W)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .drain (skid_drain),
        .din   ({sel, sel_data}),
        .full  (skid_full),
        .dout  (skid_beat)
    );

    // A parked beat is older than anything arriving now, so it wins the output.
    always_comb begin
        load_out  = 1'b0;
        clear_out = 1'b0;
        next_beat = {sel, sel_data};
        if (out_free) begin
            if (skid_full) begin
                load_out  = 1'b1;
                next_beat = skid_beat;
            end else if (acc_legal) begin
                load_out = 1'b1;
            end else begin
                clear_out = 1'b1;
            end
        end
    end
`else
    assign in_ready = !reset && (!out_valid || out_ready);

    always_comb begin
        load_out  = acc_legal;
        clear_out = out_ready && !acc_legal;
        next_beat = {sel, sel_data};
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load_out) begin
            out_valid           <= 1'b1;
            {out_sel, out_data} <= next_beat;
        end else if (clear_out) begin
            out_valid <= 1'b0;
        end
    end

    // Illegal beats are consumed silently apart from the pulse and the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            sel_err <= (beat_kind == BEAT_ILLEGAL);
            if (beat_kind == BEAT_ILLEGAL && err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_src_sel.sv
// Self-checking bench for alu_src_sel: directed vector table, stall/reset
// sequences and a random stream checked against an in-order scoreboard.
module tb_alu_src_sel;
    import alu_src_sel_pkg::*;

    localparam int WIDTH     = 32;
    localparam int N_SRC     = 5;
    localparam int SEL_W     = 3;
    localparam int ERR_CNT_W = 8;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       sel;
    logic [N_SRC*WIDTH-1:0] src_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SEL_W-1:0]       out_sel;
    logic                   sel_err;
    logic [ERR_CNT_W-1:0]   err_cnt;

    always #5 clk = ~clk;

    alu_src_sel #(
        .WIDTH(WIDTH), .N_SRC(N_SRC), .SEL_W(SEL_W), .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .src_data  (src_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } beat_t;

    typedef struct {
        logic [SEL_W-1:0]     sel;
        logic                 exp_valid;
        logic [WIDTH-1:0]     exp_data;
        logic [SEL_W-1:0]     exp_sel;
        logic                 exp_sel_err;
        logic [ERR_CNT_W-1:0] exp_cnt;
    } vec_t;

    int    n_checks = 0;
    int    n_errors = 0;
    beat_t sb_q[$];
    int    exp_err = 0;
    logic  exp_sel_err = 1'b0;
    logic  model_ok = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_SRC*WIDTH-1:0] make_src(input logic [WIDTH-1:0] base);
        logic [N_SRC*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < N_SRC; i++) r[i*WIDTH +: WIDTH] = base + WIDTH'(i);
        return r;
    endfunction

    // Scoreboard/monitor: samples mid-cycle, predicts the state after the next edge.
    always @(negedge clk) begin
        beat_t b;
        logic  exp_rdy;
        if (model_ok && !reset) begin
`ifdef ALU_SRC_SEL_SKID_EN
            exp_rdy = (sb_q.size() < 2);
`else
            exp_rdy = (sb_q.size() == 0) || out_ready;
`endif
            check("mon_out_valid", out_valid, sb_q.size() != 0);
            check("mon_in_ready", in_ready, exp_rdy);
            check("mon_sel_err", sel_err, exp_sel_err);
            check("mon_err_cnt", err_cnt, exp_err);
            if (out_valid && out_ready && sb_q.size() > 0) begin
                b = sb_q.pop_front();
                check("sb_data", out_data, b.data);
                check("sb_sel", out_sel, b.sel);
            end
        end
        if (model_ok && reset) check("mon_in_ready_reset", in_ready, 0);
        if (reset) begin
            sb_q.delete();
            exp_err     = 0;
            exp_sel_err = 1'b0;
            model_ok    = 1'b1;
        end else begin
            exp_sel_err = in_valid && in_ready && (sel >= SEL_W'(N_SRC));
            if (in_valid && in_ready) begin
                if (sel < SEL_W'(N_SRC)) begin
                    b.sel  = sel;
                    b.data = src_data[int'(sel)*WIDTH +: WIDTH];
                    sb_q.push_back(b);
                end else if (exp_err < CNT_MAX) begin
                    exp_err++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{3'd0, 1'b1, 32'd1, 3'd0, 1'b0, 8'd0};
        vecs[1] = '{3'd1, 1'b1, 32'd2, 3'd1, 1'b0, 8'd0};
        vecs[2] = '{3'd2, 1'b1, 32'd3, 3'd2, 1'b0, 8'd0};
        vecs[3] = '{3'd3, 1'b1, 32'd4, 3'd3, 1'b0, 8'd0};
        vecs[4] = '{3'd4, 1'b1, 32'd5, 3'd4, 1'b0, 8'd0};
        vecs[5] = '{3'd5, 1'b0, 32'd5, 3'd4, 1'b1, 8'd1};
        vecs[6] = '{3'd6, 1'b0, 32'd5, 3'd4, 1'b1, 8'd2};
        vecs[7] = '{3'd7, 1'b0, 32'd5, 3'd4, 1'b1, 8'd3};

        reset = 1'b1; in_valid = 1'b0; sel = '0; src_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_sel_err", sel_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // Each source in turn, then back-to-back illegal selects.
        out_ready = 1'b1;
        src_data  = make_src(32'd1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            sel      = vecs[i].sel;
            tick();
            check("vec_out_valid", out_valid, vecs[i].exp_valid);
            check("vec_out_data", out_data, vecs[i].exp_data);
            check("vec_out_sel", out_sel, vecs[i].exp_sel);
            check("vec_sel_err", sel_err, vecs[i].exp_sel_err);
            check("vec_err_cnt", err_cnt, vecs[i].exp_cnt);
        end
        in_valid = 1'b0;
        tick();
        check("vec_sel_err_end", sel_err, 0);
        check("vec_data_kept", out_data, 5);

        // Stall with changing sources.
        out_ready = 1'b0;
        src_data  = make_src(32'd0);
        src_data[2*WIDTH +: WIDTH] = 32'hDEAD;
        sel = 3'd2; in_valid = 1'b1;
        tick();
        check("stall_first", out_data, 32'hDEAD);
        sel = 3'd3;
        for (int k = 0; k < 4; k++) begin
            src_data = make_src(32'h1000 + WIDTH'(k * 16));
`ifdef ALU_SRC_SEL_SKID_EN
            check("stall_in_ready", in_ready, k == 0);
`else
            check("stall_in_ready", in_ready, 0);
`endif
            tick();
            check("stall_hold_data", out_data, 32'hDEAD);
            check("stall_hold_sel", out_sel, 2);
            check("stall_hold_valid", out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
`ifdef ALU_SRC_SEL_SKID_EN
        check("skid_drain_data", out_data, 32'h1003);
        check("skid_drain_sel", out_sel, 3);
        check("skid_drain_valid", out_valid, 1);
        tick();
`endif
        check("stall_drained", out_valid, 0);

        // Saturation of the illegal-select counter.
        in_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sel = SEL_W'(5 + (n % 3));
            tick();
        end
        check("sat_cnt", err_cnt, CNT_MAX);
        sel = 3'd7;
        tick();
        check("sat_nowrap", err_cnt, CNT_MAX);
        check("sat_sel_err", sel_err, 1);
        in_valid = 1'b0;
        tick();

        // Reset while stalled with the skid (if present) full.
        out_ready = 1'b0; src_data = make_src(32'h500);
        in_valid = 1'b1; sel = 3'd0;
        tick();
        sel = 3'd1;
        tick();
        in_valid = 1'b0;
        check("pre_rst_in_ready", in_ready, 0);
        reset = 1'b1;
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_err_cnt", err_cnt, 0);
        check("midrst_in_ready", in_ready, 0);
        reset = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_no_stale", out_valid, 0);
        end

        // Random stream.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            sel       = SEL_W'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N_SRC; i++) src_data[i*WIDTH +: WIDTH] = $urandom;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        check("stream_sb_empty", sb_q.size(), 0);
        check("stream_out_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
